// File: rtl/aes_decrypt_iter_core.sv
// Iterative AES-128 decryptor: on-chip key expansion, then one inverse round per clock.
// Start to plain_ready is 20 cycles (10 on a key-cache hit); EN=0 freezes all state, and starts while busy are ignored.
module aes_decrypt_iter_core #(
    parameter bit KEY_CACHE_EN = 1'b1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [127:0] cipher_text,
    input  logic [127:0] cipher_key,
    input  logic         decipher_new_en,
    input  logic         EN,
    output logic [127:0] plain_text,
    output logic         plain_ready,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, KEYEXP, ROUND, FINAL} fsm_t;

    fsm_t         fsm_q;
    logic [3:0]   round_q;
    logic [127:0] state_q;
    logic [127:0] ct_q;
    logic [127:0] key_q;
    logic         key_valid_q;
    logic [127:0] plain_q;
    logic         ready_q;
    logic         busy_q;
    logic [127:0] rk_q [0:10];

    logic [127:0] rk_exp_d;
    logic [127:0] state_round_d;
    logic [127:0] plain_d;
    logic         cache_hit;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254, the product of a^(2^k) for k=1..7; maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        logic [7:0] t;
        t = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
        return gf_inv(t);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        logic [7:0] r;
        case (i)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [127:0] key_expand(input logic [127:0] prev, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        w0 = prev[127:96];
        w1 = prev[95:64];
        w2 = prev[63:32];
        w3 = prev[31:0];
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h000000};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Column-major state: byte 4*c+r lives at bits [127-8*(4c+r) -: 8]; row r rotates right by r.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++)
            o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    assign rk_exp_d      = key_expand(rk_q[round_q - 4'd1], rcon(round_q));
    assign state_round_d = inv_mix_columns(inv_sub_bytes(inv_shift_rows(state_q)) ^ rk_q[round_q]);
    assign plain_d       = inv_sub_bytes(inv_shift_rows(state_q)) ^ rk_q[0];
    // key_q only ever holds the key whose schedule sits in rk_q once key_valid_q is set.
    assign cache_hit     = KEY_CACHE_EN && key_valid_q && (cipher_key == key_q);

    // Round keys carry no reset; key_valid_q alone says whether they are usable.
    always_ff @(posedge clk) begin
        if (EN) begin
            if (fsm_q == IDLE && decipher_new_en && !cache_hit)
                rk_q[0] <= cipher_key;
            else if (fsm_q == KEYEXP)
                rk_q[round_q] <= rk_exp_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q       <= IDLE;
            round_q     <= 4'd0;
            state_q     <= '0;
            ct_q        <= '0;
            key_q       <= '0;
            key_valid_q <= 1'b0;
            plain_q     <= '0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else if (EN) begin
            case (fsm_q)
                IDLE: begin
                    if (decipher_new_en) begin
                        ct_q    <= cipher_text;
                        key_q   <= cipher_key;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if (cache_hit) begin
                            state_q <= cipher_text ^ rk_q[10];
                            round_q <= 4'd9;
                            fsm_q   <= ROUND;
                        end else begin
                            key_valid_q <= 1'b0;
                            round_q     <= 4'd1;
                            fsm_q       <= KEYEXP;
                        end
                    end
                end
                KEYEXP: begin
                    if (round_q == 4'd10) begin
                        state_q     <= ct_q ^ rk_exp_d;
                        round_q     <= 4'd9;
                        key_valid_q <= 1'b1;
                        fsm_q       <= ROUND;
                    end else begin
                        round_q <= round_q + 4'd1;
                    end
                end
                ROUND: begin
                    state_q <= state_round_d;
                    round_q <= round_q - 4'd1;
                    if (round_q == 4'd1) fsm_q <= FINAL;
                end
                FINAL: begin
                    plain_q <= plain_d;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    fsm_q   <= IDLE;
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

    assign plain_text  = plain_q;
    assign plain_ready = ready_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_aes_decrypt_iter_core.sv
// Scoreboard bench for aes_decrypt_iter_core using FIPS-197 vectors; a second instance runs with the key cache disabled.
module tb_aes_decrypt_iter_core;

    localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [127:0] cipher_text;
    logic [127:0] cipher_key;
    logic         decipher_new_en;
    logic         start_nc;
    logic         EN;
    logic [127:0] plain_text, nc_text;
    logic         plain_ready, nc_ready;
    logic         busy, nc_busy;

    always #5 clk = ~clk;

    aes_decrypt_iter_core dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .cipher_text     (cipher_text),
        .cipher_key      (cipher_key),
        .decipher_new_en (decipher_new_en),
        .EN              (EN),
        .plain_text      (plain_text),
        .plain_ready     (plain_ready),
        .busy            (busy)
    );

    aes_decrypt_iter_core #(.KEY_CACHE_EN(1'b0)) dut_nc (
        .clk             (clk),
        .reset_n         (reset_n),
        .cipher_text     (cipher_text),
        .cipher_key      (cipher_key),
        .decipher_new_en (start_nc),
        .EN              (EN),
        .plain_text      (nc_text),
        .plain_ready     (nc_ready),
        .busy            (nc_busy)
    );

    typedef struct {
        logic [127:0] pt;
        int           start;
        int           lat;
    } exp_t;

    exp_t sb_q[$];
    exp_t nc_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;

    always @(posedge clk) cyc++;

    task automatic check_v(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic check_i(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input bit to_nc, input logic [127:0] pt, input int st, input int lat);
        exp_t e;
        e.pt    = pt;
        e.start = st;
        e.lat   = lat;
        if (to_nc) nc_q.push_back(e);
        else       sb_q.push_back(e);
    endtask

    logic rdy_prev = 1'b0;
    logic nc_rdy_prev = 1'b0;
    exp_t me, mn;

    always @(negedge clk) begin
        if (plain_ready === 1'b1 && rdy_prev !== 1'b1) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL dut_unexpected_ready: got ready with text %h, required no ready pulse", plain_text);
            end else begin
                me = sb_q.pop_front();
                check_v("dut_plaintext", plain_text, me.pt);
                check_i("dut_latency", cyc - me.start, me.lat);
                check_i("dut_busy_at_ready", int'(busy), 0);
            end
        end
        rdy_prev = plain_ready;
    end

    always @(negedge clk) begin
        if (nc_ready === 1'b1 && nc_rdy_prev !== 1'b1) begin
            if (nc_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL nc_unexpected_ready: got ready with text %h, required no ready pulse", nc_text);
            end else begin
                mn = nc_q.pop_front();
                check_v("nc_plaintext", nc_text, mn.pt);
                check_i("nc_latency", cyc - mn.start, mn.lat);
                check_i("nc_busy_at_ready", int'(nc_busy), 0);
            end
        end
        nc_rdy_prev = nc_ready;
    end

    task automatic wait_cyc(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while ((sb_q.size() != 0 || nc_q.size() != 0) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sb_q.size() != 0 || nc_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL timeout: %0d results pending after %0d cycles, required 0",
                     sb_q.size() + nc_q.size(), budget);
            sb_q.delete();
            nc_q.delete();
        end
    endtask

    task automatic issue(input logic [127:0] ct, input logic [127:0] key, input logic nc, output int st);
        @(negedge clk);
        cipher_text     = ct;
        cipher_key      = key;
        decipher_new_en = 1'b1;
        start_nc        = nc;
        @(posedge clk);
        #1;
        st              = cyc;
        decipher_new_en = 1'b0;
        start_nc        = 1'b0;
    endtask

    initial begin
        int s;
        reset_n         = 1'b0;
        EN              = 1'b1;
        decipher_new_en = 1'b0;
        start_nc        = 1'b0;
        cipher_text     = '0;
        cipher_key      = '0;
        repeat (2) @(posedge clk);
        #1;
        check_v("reset_plaintext", plain_text, 128'd0);
        check_i("reset_ready", int'(plain_ready), 0);
        check_i("reset_busy", int'(busy), 0);
        check_i("reset_nc_ready", int'(nc_ready), 0);
        check_i("reset_nc_busy", int'(nc_busy), 0);
        @(negedge clk) reset_n = 1'b1;

        // FIPS-197 C.1, cold cache
        issue(CT1, KEY1, 1'b0, s);
        push_exp(0, PT1, s, 20);
        check_i("c1_busy_after_start", int'(busy), 1);
        wait_cyc(s + 19);
        check_i("c1_busy_cycle19", int'(busy), 1);
        check_i("c1_ready_cycle19", int'(plain_ready), 0);
        wait_done(40);
        repeat (3) @(posedge clk);
        #1;
        check_i("c1_ready_holds", int'(plain_ready), 1);
        check_v("c1_text_holds", plain_text, PT1);

        // Same key again: cached instance 10 cycles, uncached 20
        issue(CT1, KEY1, 1'b1, s);
        push_exp(0, PT1, s, 10);
        push_exp(1, PT1, s, 20);
        wait_done(40);

        // New key, cache miss
        issue(CT2, KEY2, 1'b0, s);
        push_exp(0, PT2, s, 20);
        wait_done(40);

        // Stall 5 cycles mid-ROUND plus an ignored start while busy
        issue(CT1, KEY1, 1'b0, s);
        push_exp(0, PT1, s, 25);
        wait_cyc(s + 2);
        @(negedge clk);
        cipher_text     = CT2;
        cipher_key      = KEY2;
        decipher_new_en = 1'b1;
        @(posedge clk);
        #1;
        decipher_new_en = 1'b0;
        wait_cyc(s + 13);
        @(negedge clk) EN = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_i("stall_busy_frozen", int'(busy), 1);
        check_i("stall_ready_low", int'(plain_ready), 0);
        @(negedge clk) EN = 1'b1;
        wait_done(40);

        // Reset during KEYEXP aborts; no result expected
        issue(CT2, KEY2, 1'b0, s);
        wait_cyc(s + 4);
        @(negedge clk) reset_n = 1'b0;
        #1;
        check_v("abort_plaintext", plain_text, 128'd0);
        check_i("abort_ready", int'(plain_ready), 0);
        check_i("abort_busy", int'(busy), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        check_i("abort_no_ready", int'(plain_ready), 0);
        check_i("abort_idle", int'(busy), 0);

        // Restart after reset must take the full path
        issue(CT1, KEY1, 1'b0, s);
        push_exp(0, PT1, s, 20);
        wait_done(40);

        // Back-to-back with start held high: accepts every 11 cycles on cache hits
        @(negedge clk);
        cipher_text     = CT1;
        cipher_key      = KEY1;
        decipher_new_en = 1'b1;
        @(posedge clk);
        #1;
        s = cyc;
        for (int k = 0; k < 3; k++) push_exp(0, PT1, s + 11 * k, 10);
        for (int k = 1; k < 3; k++) begin
            wait_cyc(s + 11 * k);
            check_i("b2b_ready_cleared", int'(plain_ready), 0);
            check_i("b2b_busy_on_accept", int'(busy), 1);
        end
        decipher_new_en = 1'b0;
        wait_done(60);
        repeat (3) @(posedge clk);
        #1;
        check_i("b2b_idle_after", int'(busy), 0);
        check_i("b2b_ready_held", int'(plain_ready), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_decrypt_iter_core.md
Name: aes_decrypt_iter_core

Overview:
- Iterative AES-128 decryption core; the inverse of the existing AES-128 encrypt top module.
- Accepts a 128-bit ciphertext and cipher key, expands the key schedule on chip and runs 10 inverse rounds, one per clock.
- Delivers plaintext with a ready flag.
- Sits beside the encrypt top module and shares its S-box, Rcon, ShiftRow and GF multiply function packages; adds inverse S-box, InvShiftRows and InvMixColumns.

Parameters:
- KEY_CACHE_EN, 1, 1 = skip key expansion when the new key equals the last fully expanded key; 0 = always expand.

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- cipher_text  input  128  ciphertext block; byte 0 = bits [127:120]
- cipher_key  input  128  AES-128 key, same byte order
- decipher_new_en  input  1  start request, sampled on rising clk
- EN  input  1  global enable; 0 freezes all state
- plain_text  output  128  recovered plaintext, registered
- plain_ready  output  1  plain_text valid
- busy  output  1  operation in progress

Behaviour:
- Reset (async, reset_n=0): plain_text=0, plain_ready=0, busy=0, FSM=IDLE, round counter=0, key_valid=0. Round-key array is not reset. Reset mid-operation aborts immediately; no ready pulse follows.
- EN=0: every register holds (FSM, counter, state, outputs); start is ignored. EN=1 resumes exactly where frozen.
- Start accept: decipher_new_en=1 and EN=1 and FSM=IDLE at a rising edge (T0).
  - Latch ct and key; clear plain_ready; set busy.
  - Starts while busy are ignored and have no effect on the running operation.
- FSM states: IDLE, KEYEXP, ROUND, FINAL.
- Full path (cache miss, or KEY_CACHE_EN=0):
  - T0: IDLE->KEYEXP; rk[0] = key.
  - T1..T10 (KEYEXP): rk[i] = standard AES-128 expansion of rk[i-1] with RotWord, SubWord and Rcon[i]. At T10, also compute state = ct ^ rk[10] using the combinational rk[10].
  - Then ->ROUND with r=9, key_valid=1, stored key = latched key.
- Cache hit (KEY_CACHE_EN=1, key_valid=1, cipher_key == stored key at T0):
  - T0 loads state = ct ^ rk[10] directly; IDLE->ROUND with r=9.
- ROUND, r=9 down to 1, one edge each: state = InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk[r]). After r=1, ->FINAL.
- FINAL, one edge: plain_text = InvSubBytes(InvShiftRows(state)) ^ rk[0]; plain_ready=1; busy=0; ->IDLE.
- Latency from the start edge to plain_ready high: 20 cycles on the full path, 10 cycles on a cache hit. Both exclude EN=0 cycles.
- plain_ready and plain_text hold until the next accepted start or reset.
- A start in the same cycle that FINAL completes is not accepted (FSM is not yet IDLE). It is accepted on the following edge if still asserted.
- Inputs may change after T0 without effect.
- key_valid stays 0 if KEYEXP is aborted by reset.

Test Plan:
- FIPS-197 C.1: ct=69c4e0d86a7b0430d8cdb78070b4c55a, key=000102030405060708090a0b0c0d0e0f, 1-cycle start -> plain_text=00112233445566778899aabbccddeeff, plain_ready rises exactly 20 cycles after the start edge, busy high for 20 cycles.
- Cache hit: repeat the same key with the same ct -> same plaintext after 10 cycles. With KEY_CACHE_EN=0 the same sequence takes 20 cycles.
- Key change: key=2b7e151628aed2a6abf7158809cf4f3c, ct=3925841d02dc09fbdc118597196a0b32 -> plain_text=3243f6a8885a308d313198a2e0370734 after 20 cycles (cache miss).
- Stall/ignore: hold EN=0 for 5 cycles mid-ROUND and pulse decipher_new_en with different data while busy -> correct C.1 plaintext after 25 cycles; the second start has no effect.
- Reset mid-KEYEXP at cycle 5 -> all outputs 0. Restart with the C.1 key -> full 20-cycle path (no false cache hit), correct result.
- Back-to-back: hold decipher_new_en high continuously -> starts accepted one cycle after each plain_ready rise; plain_ready clears on each accept.
